// File: rtl/hsdac_pkg.sv
// -----------------------------------------------------------------------------
// hsdac_pkg
// Shared types and constants for the high-speed DAC playback driver.
//
// Contents:
//   hsdac_driver_state_t : driver FSM states (IDLE, WAIT, FETCH, STROBE)
//   CHAN_WIDTH           : width of one DAC channel code (8)
//   SAMPLE_WIDTH         : width of one AXI-stream beat, channel A:B (16)
//   ZERO_CODE_TWOS       : mid-scale code for two's-complement DACs (8'h00)
//   ZERO_CODE_OFFSET     : mid-scale code for offset-binary DACs (8'h80)
//   ZERO_CODE            : code the DAC buses reset to in this build
//   to_dac_code()        : converts an incoming channel code to the DAC format
//
// Build option:
//   HSDAC_OFFSET_BINARY_EN - when defined, incoming two's-complement codes are
//   converted to offset binary (bit 7 inverted) and the DAC buses reset to
//   8'h80. When undefined, codes pass through and the buses reset to 8'h00.
// -----------------------------------------------------------------------------
package hsdac_pkg;

   localparam int CHAN_WIDTH   = 8;
   localparam int SAMPLE_WIDTH = 16;

   localparam logic [CHAN_WIDTH-1:0] ZERO_CODE_TWOS   = 8'h00;
   localparam logic [CHAN_WIDTH-1:0] ZERO_CODE_OFFSET = 8'h80;

`ifdef HSDAC_OFFSET_BINARY_EN
   localparam logic [CHAN_WIDTH-1:0] ZERO_CODE = ZERO_CODE_OFFSET;
`else
   localparam logic [CHAN_WIDTH-1:0] ZERO_CODE = ZERO_CODE_TWOS;
`endif

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT   = 2'd1,
      FETCH  = 2'd2,
      STROBE = 2'd3
   } hsdac_driver_state_t;

   // Two's complement to offset binary is a flip of the sign bit.
   function automatic logic [CHAN_WIDTH-1:0] to_dac_code(
      input logic [CHAN_WIDTH-1:0] code
   );
`ifdef HSDAC_OFFSET_BINARY_EN
      return {~code[CHAN_WIDTH-1], code[CHAN_WIDTH-2:0]};
`else
      return code;
`endif
   endfunction

endpackage

// File: rtl/hsdac_rate_divider.sv
// -----------------------------------------------------------------------------
// hsdac_rate_divider
// Free-running modulo-DIVIDER counter that sets the DAC sample period.
//
// Ports:
//   clk  in   clock
//   rst  in   asynchronous active-high reset (count -> 0)
//   en   in   count enable; counter advances 0..DIVIDER-1 and wraps
//   clr  in   synchronous clear to 0, takes priority over en
//   tc   out  terminal count, high while the counter sits at DIVIDER-1
//
// Parameters:
//   DIVIDER : period in clocks, legal range 4..65535
// -----------------------------------------------------------------------------
module hsdac_rate_divider #(
   parameter int unsigned DIVIDER = 10
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic tc
);

   // 16 bits covers the whole legal DIVIDER range.
   localparam logic [15:0] LAST = 16'(DIVIDER - 1);

   logic [15:0] count_d;
   logic [15:0] count_q;

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (en) begin
         count_d = (count_q == LAST) ? 16'd0 : count_q + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign tc = (count_q == LAST);

endmodule

// File: rtl/hsdac_axis_driver.sv
// -----------------------------------------------------------------------------
// hsdac_axis_driver
// Plays back a 16-bit AXI stream of sample pairs onto a dual 8-bit parallel
// DAC at one pair per DIVIDER sample clocks.
//
// Ports:
//   sample_clk      in   sole clock
//   reset           in   asynchronous active-high reset
//   enable          in   playback runs while high
//   s_axis_tdata    in   [15:8] channel A code, [7:0] channel B code
//   s_axis_tvalid   in   stream valid
//   s_axis_tready   out  stream ready, high only in the FETCH slot
//   s_axis_tlast    in   ignored
//   dac_a, dac_b    out  registered DAC data buses
//   dac_wr          out  DAC latch strobe (DAC latches on rising edge)
//   underrun_count  out  saturating count of slots with no data available
//   active          out  high while the driver is not IDLE
//
// Parameters:
//   DIVIDER         : clocks per output sample, 4..65535
//   UNDERRUN_WIDTH  : width of underrun_count
//
// Build option:
//   HSDAC_OFFSET_BINARY_EN - convert codes to offset binary, reset buses to 8'h80.
// -----------------------------------------------------------------------------
module hsdac_axis_driver
   import hsdac_pkg::*;
#(
   parameter int unsigned DIVIDER        = 10,
   parameter int unsigned UNDERRUN_WIDTH = 16
) (
   input  logic                      sample_clk,
   input  logic                      reset,
   input  logic                      enable,
   input  logic [SAMPLE_WIDTH-1:0]   s_axis_tdata,
   input  logic                      s_axis_tvalid,
   output logic                      s_axis_tready,
   input  logic                      s_axis_tlast,
   output logic [CHAN_WIDTH-1:0]     dac_a,
   output logic [CHAN_WIDTH-1:0]     dac_b,
   output logic                      dac_wr,
   output logic [UNDERRUN_WIDTH-1:0] underrun_count,
   output logic                      active
);

   function automatic logic [UNDERRUN_WIDTH-1:0] sat_inc(
      input logic [UNDERRUN_WIDTH-1:0] v
   );
      return (&v) ? v : v + UNDERRUN_WIDTH'(1);
   endfunction

   hsdac_driver_state_t state_d, state_q;
   logic [CHAN_WIDTH-1:0]     dac_a_d, dac_a_q;
   logic [CHAN_WIDTH-1:0]     dac_b_d, dac_b_q;
   logic                      dac_wr_d, dac_wr_q;
   logic [UNDERRUN_WIDTH-1:0] underrun_d, underrun_q;
   logic                      div_tc;
   logic                      handshake;
   logic                      unused_tlast;

   assign unused_tlast = s_axis_tlast;

   // The counter is cleared whenever playback is disabled and counts on the
   // same edge that leaves IDLE, so the first FETCH lands exactly DIVIDER
   // clocks after enable is sampled and every later period is DIVIDER long.
   hsdac_rate_divider #(
      .DIVIDER (DIVIDER)
   ) u_rate_divider (
      .clk (sample_clk),
      .rst (reset),
      .en  (enable),
      .clr (~enable),
      .tc  (div_tc)
   );

   assign s_axis_tready = (state_q == FETCH);
   assign handshake     = s_axis_tready && s_axis_tvalid;

   always_comb begin
      state_d    = state_q;
      dac_a_d    = dac_a_q;
      dac_b_d    = dac_b_q;
      underrun_d = underrun_q;

      case (state_q)
         IDLE: begin
            if (enable) begin
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (div_tc) begin
               state_d = FETCH;
            end
         end
         FETCH: begin
            if (s_axis_tvalid) begin
               state_d = STROBE;
            end else begin
               state_d    = WAIT;
               underrun_d = sat_inc(underrun_q);
            end
         end
         STROBE: begin
            state_d = WAIT;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // A beat accepted in FETCH is always latched, even if enable drops on
      // the same edge; only the strobe is suppressed in that case.
      if (handshake) begin
         dac_a_d = to_dac_code(s_axis_tdata[15:8]);
         dac_b_d = to_dac_code(s_axis_tdata[7:0]);
      end

      if (!enable) begin
         state_d = IDLE;
      end

      // Strobe is high for exactly the one cycle spent in STROBE.
      dac_wr_d = (state_d == STROBE);
   end

   always_ff @(posedge sample_clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         dac_a_q    <= ZERO_CODE;
         dac_b_q    <= ZERO_CODE;
         dac_wr_q   <= 1'b0;
         underrun_q <= '0;
      end else begin
         state_q    <= state_d;
         dac_a_q    <= dac_a_d;
         dac_b_q    <= dac_b_d;
         dac_wr_q   <= dac_wr_d;
         underrun_q <= underrun_d;
      end
   end

   assign dac_a          = dac_a_q;
   assign dac_b          = dac_b_q;
   assign dac_wr         = dac_wr_q;
   assign underrun_count = underrun_q;
   assign active         = (state_q != IDLE);

endmodule
